// File: rtl/bp_me_pkg.sv
// Shared memory-message types and source ids for the boot-time I/O load path.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic {
        e_load_src_cfg = 1'b0,
        e_load_src_nbf = 1'b1
    } bp_me_load_arb_src_e;

    localparam int paddr_width_gp    = 40;
    localparam int block_width_gp    = 64;
    localparam int lce_id_width_gp   = 2;
    localparam int msg_type_width_gp = 4;
    localparam int msg_size_width_gp = 3;

    typedef struct packed {
        logic [msg_type_width_gp-1:0] msg_type;
        logic [lce_id_width_gp-1:0]   lce_id;
        logic [msg_size_width_gp-1:0] size;
        logic [paddr_width_gp-1:0]    addr;
        logic [block_width_gp-1:0]    data;
    } bp_cce_mem_msg_s;

    function automatic int bp_cce_mem_msg_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return $bits(bp_cce_mem_msg_s);
            default:          return $bits(bp_cce_mem_msg_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_me_load_arb_src_fifo.sv
// In-order record of which master issued each outstanding I/O command.
module bp_me_load_arb_src_fifo
    import bp_me_pkg::*;
#(
    parameter  int depth_p      = 4,
    localparam int ptr_width_lp = $clog2(depth_p)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  bp_me_load_arb_src_e push_id,
    input  logic                pop,
    output bp_me_load_arb_src_e head_id,
    output logic                full,
    output logic                empty
);

    logic [depth_p-1:0]      entries;
    logic [ptr_width_lp-1:0] wptr;
    logic [ptr_width_lp-1:0] rptr;
    logic [ptr_width_lp:0]   count;
    logic                    do_push;
    logic                    do_pop;

    assign full    = (count == (ptr_width_lp+1)'(depth_p));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = bp_me_load_arb_src_e'(entries[rptr]);

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entries <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
        end else begin
            if (do_push) begin
                entries[wptr] <= push_id;
                wptr          <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_me_load_cmd_arbiter.sv
// Merges the CCE config loader and NBF loader onto one I/O port and routes responses back in order.
// BP_ME_LOAD_ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins ties) instead of round-robin.
module bp_me_load_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter  bp_params_e bp_params_p          = e_bp_default_cfg,
    parameter  int         max_outstanding_p    = 4,
    localparam int         cce_mem_msg_width_lp = bp_cce_mem_msg_width(bp_params_p)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [1:0][cce_mem_msg_width_lp-1:0] m_cmd_i,
    input  logic [1:0]                           m_cmd_v_i,
    output logic [1:0]                           m_cmd_yumi_o,
    output logic [1:0][cce_mem_msg_width_lp-1:0] m_resp_o,
    output logic [1:0]                           m_resp_v_o,
    input  logic [1:0]                           m_resp_ready_i,
    output logic [cce_mem_msg_width_lp-1:0]      io_cmd_o,
    output logic                                 io_cmd_v_o,
    input  logic                                 io_cmd_yumi_i,
    input  logic [cce_mem_msg_width_lp-1:0]      io_resp_i,
    input  logic                                 io_resp_v_i,
    output logic                                 io_resp_ready_o
);

    bp_me_load_arb_src_e arb_grant;
    bp_me_load_arb_src_e grant;
    bp_me_load_arb_src_e locked_grant;
    bp_me_load_arb_src_e head_id;
    logic                grant_lock;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

`ifndef BP_ME_LOAD_ARB_FIXED_PRIO_EN
    logic rr_last;
`endif

    always_comb begin
        arb_grant = e_load_src_cfg;
        if (&m_cmd_v_i) begin
`ifdef BP_ME_LOAD_ARB_FIXED_PRIO_EN
            arb_grant = e_load_src_cfg;
`else
            arb_grant = rr_last ? e_load_src_cfg : e_load_src_nbf;
`endif
        end else if (m_cmd_v_i[1]) begin
            arb_grant = e_load_src_nbf;
        end
    end

    // A stalled offer keeps its grant so the payload cannot change under the wrapper.
    assign grant = grant_lock ? locked_grant : arb_grant;

    assign io_cmd_v_o   = ~reset_i & (|m_cmd_v_i) & ~full;
    assign io_cmd_o     = m_cmd_i[grant];
    assign m_cmd_yumi_o = (~reset_i & io_cmd_yumi_i)
                        ? ((grant == e_load_src_nbf) ? 2'b10 : 2'b01) : 2'b00;
    assign push         = io_cmd_yumi_i & io_cmd_v_o;

    assign io_resp_ready_o = ~reset_i & ~empty & m_resp_ready_i[head_id];
    assign m_resp_v_o      = (~reset_i & io_resp_v_i & ~empty)
                           ? ((head_id == e_load_src_nbf) ? 2'b10 : 2'b01) : 2'b00;
    assign m_resp_o        = {io_resp_i, io_resp_i};
    assign pop             = io_resp_v_i & io_resp_ready_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            grant_lock   <= 1'b0;
            locked_grant <= e_load_src_cfg;
        end else begin
            grant_lock   <= io_cmd_v_o & ~io_cmd_yumi_i;
            locked_grant <= grant;
        end
    end

`ifndef BP_ME_LOAD_ARB_FIXED_PRIO_EN
    // Reset value of 1 lets master 0 win the first tie.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_last <= 1'b1;
        end else if (push) begin
            rr_last <= grant;
        end
    end
`endif

    bp_me_load_arb_src_fifo #(
        .depth_p(max_outstanding_p)
    ) src_fifo (
        .clk    (clk_i),
        .reset  (reset_i),
        .push   (push),
        .push_id(grant),
        .pop    (pop),
        .head_id(head_id),
        .full   (full),
        .empty  (empty)
    );

`ifndef SYNTHESIS
    resp_while_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        io_resp_v_i |-> !empty);
    yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        io_cmd_yumi_i |-> io_cmd_v_o);
`endif

endmodule

// File: tb/tb_bp_me_load_cmd_arbiter.sv
// Randomized and directed bench for bp_me_load_cmd_arbiter against a queue-based reference model.
module tb_bp_me_load_cmd_arbiter;
    import bp_me_pkg::*;

    localparam int W   = bp_cce_mem_msg_width(e_bp_default_cfg);
    localparam int MAX = 4;

    logic                clk_i;
    logic                reset_i;
    logic [1:0][W-1:0]   m_cmd_i;
    logic [1:0]          m_cmd_v_i;
    logic [1:0]          m_cmd_yumi_o;
    logic [1:0][W-1:0]   m_resp_o;
    logic [1:0]          m_resp_v_o;
    logic [1:0]          m_resp_ready_i;
    logic [W-1:0]        io_cmd_o;
    logic                io_cmd_v_o;
    logic                io_cmd_yumi_i;
    logic [W-1:0]        io_resp_i;
    logic                io_resp_v_i;
    logic                io_resp_ready_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of issuing masters plus arbitration history.
    int src_q[$];
    bit mdl_rr_last;
    bit mdl_locked;
    int mdl_locked_id;
    int mdl_yumi_g;
    logic [1:0] last_yumi;

    bp_me_load_cmd_arbiter #(
        .bp_params_p      (e_bp_default_cfg),
        .max_outstanding_p(MAX)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .m_cmd_i        (m_cmd_i),
        .m_cmd_v_i      (m_cmd_v_i),
        .m_cmd_yumi_o   (m_cmd_yumi_o),
        .m_resp_o       (m_resp_o),
        .m_resp_v_o     (m_resp_v_o),
        .m_resp_ready_i (m_resp_ready_i),
        .io_cmd_o       (io_cmd_o),
        .io_cmd_v_o     (io_cmd_v_o),
        .io_cmd_yumi_i  (io_cmd_yumi_i),
        .io_resp_i      (io_resp_i),
        .io_resp_v_i    (io_resp_v_i),
        .io_resp_ready_o(io_resp_ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_msg();
        return W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    function automatic logic [W-1:0] make_msg(input logic [39:0] addr);
        bp_cce_mem_msg_s m;
        m          = '0;
        m.msg_type = 4'h1;
        m.addr     = addr;
        return m;
    endfunction

    task automatic modelReset();
        src_q.delete();
        mdl_rr_last = 1'b1;
        mdl_locked  = 1'b0;
        mdl_locked_id = 0;
    endtask

    task automatic resetDut();
        reset_i        = 1'b1;
        m_cmd_v_i      = 2'b00;
        io_cmd_yumi_i  = 1'b0;
        io_resp_v_i    = 1'b0;
        m_resp_ready_i = 2'b00;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus: yumi/response are only offered where they are legal.
    task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] c0, input logic [W-1:0] c1,
                                 input bit want_yumi, input bit want_resp, input logic [1:0] ready);
        bit           exp_v;
        bit           exp_ready;
        int           g;
        int           head;
        logic [1:0]   exp_yumi;
        logic [1:0]   exp_rv;
        logic [W-1:0] resp_data;

        exp_v = (v != 2'b00) && (src_q.size() < MAX);
        if (mdl_locked)
            g = mdl_locked_id;
        else if (v == 2'b11)
`ifdef BP_ME_LOAD_ARB_FIXED_PRIO_EN
            g = 0;
`else
            g = mdl_rr_last ? 0 : 1;
`endif
        else
            g = v[1] ? 1 : 0;
        head = (src_q.size() > 0) ? src_q[0] : 0;

        m_cmd_v_i      = v;
        m_cmd_i[0]     = c0;
        m_cmd_i[1]     = c1;
        m_resp_ready_i = ready;
        io_cmd_yumi_i  = want_yumi && exp_v;
        io_resp_v_i    = want_resp && (src_q.size() > 0);
        resp_data      = rand_msg();
        io_resp_i      = resp_data;

        exp_yumi  = io_cmd_yumi_i ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
        exp_ready = (src_q.size() > 0) && ready[head];
        exp_rv    = io_resp_v_i ? ((head == 1) ? 2'b10 : 2'b01) : 2'b00;

        #1;
        checkOutput("cmd_v", W'(io_cmd_v_o), W'(exp_v));
        if (exp_v) checkOutput("cmd_payload", io_cmd_o, (g == 1) ? c1 : c0);
        checkOutput("cmd_yumi", W'(m_cmd_yumi_o), W'(exp_yumi));
        checkOutput("resp_v", W'(m_resp_v_o), W'(exp_rv));
        checkOutput("resp_ready", W'(io_resp_ready_o), W'(exp_ready));
        if (io_resp_v_i && exp_ready) checkOutput("resp_data", m_resp_o[head], resp_data);
        last_yumi = m_cmd_yumi_o;

        @(posedge clk_i); #1;
        mdl_yumi_g = -1;
        if (io_cmd_yumi_i) begin
            src_q.push_back(g);
            mdl_rr_last = (g == 1);
            mdl_locked  = 1'b0;
            mdl_yumi_g  = g;
        end else begin
            mdl_locked    = exp_v;
            mdl_locked_id = g;
        end
        if (io_resp_v_i && exp_ready) void'(src_q.pop_front());
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * MAX && src_q.size() > 0; i++)
            applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 2'b11);
        checkOutput("drained", W'(src_q.size()), W'(0));
    endtask

    logic [1:0]   pv;
    logic [W-1:0] pc0;
    logic [W-1:0] pc1;
    logic [1:0]   t2_exp [4];
    logic [W-1:0] a0;
    logic [W-1:0] a1;

    initial begin
        m_cmd_i = '0;
        io_resp_i = '0;
        modelReset();

        // Reset state, even with masters asserting valid.
        reset_i        = 1'b1;
        m_cmd_v_i      = 2'b11;
        m_resp_ready_i = 2'b11;
        io_cmd_yumi_i  = 1'b0;
        io_resp_v_i    = 1'b0;
        #1;
        checkOutput("rst_cmd_v", W'(io_cmd_v_o), W'(0));
        checkOutput("rst_yumi", W'(m_cmd_yumi_o), W'(0));
        checkOutput("rst_resp_v", W'(m_resp_v_o), W'(0));
        checkOutput("rst_resp_ready", W'(io_resp_ready_o), W'(0));
        resetDut();

        // Single master 0 command, same-cycle yumi, response back to master 0.
        a0 = make_msg(40'h00_0020_0000);
        applyStimulus(2'b01, a0, '0, 1'b1, 1'b0, 2'b11);
        checkOutput("t1_yumi", W'(last_yumi), W'(2'b01));
        applyStimulus(2'b00, '0, '0, 1'b0, 1'b1, 2'b11);

        // Both valid, yumi every cycle.
        resetDut();
`ifdef BP_ME_LOAD_ARB_FIXED_PRIO_EN
        t2_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        t2_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        a0 = make_msg(40'h00_0000_1000);
        a1 = make_msg(40'h00_0000_2000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
            checkOutput("t2_grant", W'(last_yumi), W'(t2_exp[i]));
        end
        drain();

        // Fill to capacity, then one response frees a slot a cycle later.
        for (int i = 0; i < 4; i++) applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        checkOutput("t3_full_v", W'(io_cmd_v_o), W'(0));
        applyStimulus(2'b11, a0, a1, 1'b0, 1'b1, 2'b11);
        applyStimulus(2'b11, a0, a1, 1'b0, 1'b0, 2'b11);
        checkOutput("t3_reopen_v", W'(io_cmd_v_o), W'(1));
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b0, 2'b11);
        drain();

        // Issue m1, m0, m1; stall the m0 response with its ready low.
        applyStimulus(2'b10, a0, a1, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b01, a0, a1, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b10, a0, a1, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b1, 2'b11);
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b1, 2'b10);
        checkOutput("t4_stall_ready", W'(io_resp_ready_o), W'(0));
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b1, 2'b10);
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b1, 2'b11);
        applyStimulus(2'b00, a0, a1, 1'b0, 1'b1, 2'b11);
        checkOutput("t4_all_out", W'(src_q.size()), W'(0));

        // Wrapper stalls while m1 becomes valid mid-stall.
        applyStimulus(2'b01, a0, a1, 1'b0, 1'b0, 2'b11);
        applyStimulus(2'b11, a0, a1, 1'b0, 1'b0, 2'b11);
        applyStimulus(2'b11, a0, a1, 1'b0, 1'b0, 2'b11);
        checkOutput("t5_payload", io_cmd_o, a0);
        applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        checkOutput("t5_grant", W'(last_yumi), W'(2'b01));
        applyStimulus(2'b10, a0, a1, 1'b1, 1'b0, 2'b11);
        drain();

        // Randomized traffic with well-behaved masters.
        pv = 2'b00;
        pc0 = '0;
        pc1 = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!pv[0] && $urandom_range(0, 2) == 0) begin pv[0] = 1'b1; pc0 = rand_msg(); end
            if (!pv[1] && $urandom_range(0, 2) == 0) begin pv[1] = 1'b1; pc1 = rand_msg(); end
            applyStimulus(pv, pc0, pc1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          2'($urandom));
            if (mdl_yumi_g >= 0) pv[mdl_yumi_g] = 1'b0;
        end
        drain();

        // Asynchronous reset with three commands outstanding.
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        m_cmd_v_i      = 2'b11;
        io_cmd_yumi_i  = 1'b0;
        io_resp_v_i    = 1'b0;
        m_resp_ready_i = 2'b11;
        #2;
        reset_i = 1'b1;
        #1;
        checkOutput("t6_cmd_v", W'(io_cmd_v_o), W'(0));
        checkOutput("t6_yumi", W'(m_cmd_yumi_o), W'(0));
        checkOutput("t6_resp_ready", W'(io_resp_ready_o), W'(0));
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        modelReset();
        applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        checkOutput("t6_first_grant", W'(last_yumi), W'(2'b01));
        for (int i = 0; i < 3; i++) applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b11, a0, a1, 1'b1, 1'b0, 2'b11);
        checkOutput("t6_full_after_4", W'(io_cmd_v_o), W'(0));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
